// File: rtl/sdram_pkg.sv
// Definitions shared by the SDRAM write-side and read-side burst engines:
// FSM state encoding and default geometry.
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    DATA      = 2'd2,
    WAIT_DONE = 2'd3
  } burst_state_e;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_WIDTH  = 10;
  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_BURST_LEN  = 8;

endpackage

// File: rtl/sdram_wr_burst_reader.sv
// Drains the SDRAM write FIFO in whole bursts (or a flushed partial burst),
// feeding the controller word by word and tracking a wrapping write address.
module sdram_wr_burst_reader
  import sdram_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WIDTH  = DEF_NUM_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = '1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [NUM_WIDTH-1:0]  fifo_use_num,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_req,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  wr_burst_req,
  output logic [ADDR_WIDTH-1:0] wr_burst_addr,
  output logic [NUM_WIDTH-1:0]  wr_burst_len,
  input  logic                  wr_burst_ack,
  input  logic                  wr_data_req,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_burst_done,
  output logic                  busy
);

  localparam logic [NUM_WIDTH-1:0] BURST_LEN_W = NUM_WIDTH'(BURST_LEN);

  burst_state_e          state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0] burst_addr_reg, burst_addr_next;
  logic [NUM_WIDTH-1:0]  len_reg, len_next;
  logic [NUM_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  early_done_reg, early_done_next;
  logic                  pop_d_reg;
  logic [DATA_WIDTH-1:0] wr_data_reg;

  logic                  launch;
  logic                  full_burst;
  logic                  pop;
  logic                  finish;
  logic [ADDR_WIDTH:0]   addr_sum;
  logic [ADDR_WIDTH-1:0] addr_adv;

  assign full_burst = (fifo_use_num >= BURST_LEN_W);
  assign launch     = enable && (full_burst || (flush && !fifo_empty));
  assign pop        = (state_reg == DATA) && wr_data_req && (cnt_reg < len_reg) && !fifo_empty;

  // Finish on the pop that reaches len; the cnt >= len term covers a zero-length launch.
  assign finish = (state_reg == DATA) &&
                  ((pop && ({1'b0, cnt_reg} + (NUM_WIDTH+1)'(1) >= {1'b0, len_reg})) ||
                   (cnt_reg >= len_reg));

  // One extra bit so a sum past the top of the address space cannot alias low.
  assign addr_sum = {1'b0, addr_reg} + (ADDR_WIDTH+1)'(len_reg);
  assign addr_adv = (addr_sum > {1'b0, ADDR_LIMIT}) ? ADDR_BASE : addr_sum[ADDR_WIDTH-1:0];

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    burst_addr_next = burst_addr_reg;
    len_next        = len_reg;
    cnt_next        = cnt_reg;
    early_done_next = early_done_reg;
    case (state_reg)
      IDLE: begin
        if (launch) begin
          state_next      = REQ;
          len_next        = full_burst ? BURST_LEN_W : fifo_use_num;
          burst_addr_next = addr_reg;
        end
      end
      REQ: begin
        if (wr_burst_ack) begin
          state_next      = DATA;
          cnt_next        = '0;
          early_done_next = 1'b0;
        end
      end
      DATA: begin
        if (pop) cnt_next = cnt_reg + 1'b1;
        if (wr_burst_done) early_done_next = 1'b1;
        if (finish) begin
          // A done that already arrived means nothing more is coming from the controller.
          if (early_done_reg || wr_burst_done) begin
            state_next = IDLE;
            addr_next  = addr_adv;
          end else begin
            state_next = WAIT_DONE;
          end
        end
      end
      WAIT_DONE: begin
        if (wr_burst_done) begin
          state_next = IDLE;
          addr_next  = addr_adv;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      addr_reg       <= ADDR_BASE;
      burst_addr_reg <= ADDR_BASE;
      len_reg        <= '0;
      cnt_reg        <= '0;
      early_done_reg <= 1'b0;
      pop_d_reg      <= 1'b0;
      wr_data_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      burst_addr_reg <= burst_addr_next;
      len_reg        <= len_next;
      cnt_reg        <= cnt_next;
      early_done_reg <= early_done_next;
      pop_d_reg      <= pop;
      if (pop_d_reg) wr_data_reg <= fifo_rd_data;
    end
  end

  assign fifo_rd_req   = pop;
  assign wr_burst_req  = (state_reg == REQ);
  assign wr_burst_addr = burst_addr_reg;
  assign wr_burst_len  = len_reg;
  assign wr_data       = wr_data_reg;
  assign busy          = (state_reg != IDLE);

endmodule

// File: tb/tb_sdram_wr_burst_reader.sv
// Bench for sdram_wr_burst_reader: a queue-based FIFO feeds the DUT, and the
// bench plays the SDRAM controller, checking burst fields, pop counts and data order.
module tb_sdram_wr_burst_reader;

  localparam int DW = 16;
  localparam int NW = 10;
  localparam int AW = 24;
  localparam int BL = 8;
  localparam int LIMIT = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          flush = 1'b0;
  logic [NW-1:0] fifo_use_num = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_req;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          wr_burst_req;
  logic [AW-1:0] wr_burst_addr;
  logic [NW-1:0] wr_burst_len;
  logic          wr_burst_ack = 1'b0;
  logic          wr_data_req = 1'b0;
  logic [DW-1:0] wr_data;
  logic          wr_burst_done = 1'b0;
  logic          busy;

  logic          fifo_wr = 1'b0;
  logic          fifo_clr = 1'b0;
  logic [DW-1:0] fifo_wdata = '0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int pop_cnt = 0;
  bit pipe0 = 1'b0;
  bit pipe1 = 1'b0;
  int model_addr = 0;
  int next_val = 1;

  always #5 clk = ~clk;

  sdram_wr_burst_reader #(
    .DATA_WIDTH(DW), .NUM_WIDTH(NW), .ADDR_WIDTH(AW), .BURST_LEN(BL),
    .ADDR_BASE(24'd0), .ADDR_LIMIT(24'd31)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .fifo_use_num(fifo_use_num), .fifo_empty(fifo_empty),
    .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data),
    .wr_burst_req(wr_burst_req), .wr_burst_addr(wr_burst_addr),
    .wr_burst_len(wr_burst_len), .wr_burst_ack(wr_burst_ack),
    .wr_data_req(wr_data_req), .wr_data(wr_data),
    .wr_burst_done(wr_burst_done), .busy(busy)
  );

  // FIFO with one cycle read latency and registered level/empty flags.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_q.delete();
    end else begin
      if (fifo_rd_req && fifo_q.size() > 0) fifo_rd_data <= fifo_q.pop_front();
      if (fifo_wr) fifo_q.push_back(fifo_wdata);
    end
    fifo_use_num <= NW'(fifo_q.size());
    fifo_empty   <= (fifo_q.size() == 0);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // One clock: pops and 2-cycle-late data are observed at the negedge,
  // then control returns just after the next rising edge.
  task automatic step();
    @(negedge clk);
    if (fifo_rd_req) pop_cnt++;
    if (pipe1 && exp_q.size() > 0) chk("wr_data", 32'(wr_data), 32'(exp_q.pop_front()));
    pipe1 = pipe0;
    pipe0 = fifo_rd_req;
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(int n, bit rnd);
    for (int i = 0; i < n; i++) begin
      fifo_wr    = 1'b1;
      fifo_wdata = rnd ? DW'($urandom) : DW'(next_val);
      next_val++;
      exp_q.push_back(fifo_wdata);
      step();
    end
    fifo_wr = 1'b0;
  endtask

  task automatic no_req_for(string name, int cycles);
    bit saw = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (wr_burst_req) saw = 1'b1;
    end
    chk(name, 32'(saw), 0);
  endtask

  // mode 0: back-to-back requests, 1: every other cycle, 2: random gaps.
  task automatic do_burst(int len, int addr, int mode, bit early);
    int t = 0;
    int issued = 0;
    int start;
    bit req;
    while (wr_burst_req !== 1'b1 && t < 60) begin
      step();
      t++;
    end
    chk("req_seen", 32'(wr_burst_req), 1);
    chk("burst_addr", 32'(wr_burst_addr), 32'(addr));
    chk("burst_len", 32'(wr_burst_len), 32'(len));
    wr_burst_ack = 1'b1;
    step();
    wr_burst_ack = 1'b0;
    chk("req_drop_after_ack", 32'(wr_burst_req), 0);
    start = pop_cnt;
    if (early) begin
      wr_burst_done = 1'b1;
      step();
      wr_burst_done = 1'b0;
    end
    t = 0;
    while (issued < len && t < 300) begin
      case (mode)
        0: req = 1'b1;
        1: req = (t % 2 == 0);
        default: req = $urandom_range(0, 1) == 1;
      endcase
      wr_data_req = req;
      if (req) issued++;
      step();
      t++;
    end
    wr_data_req = 1'b1;  // stray request past the end of the burst
    step();
    wr_data_req = 1'b0;
    step();
    step();
    chk("pop_count", 32'(pop_cnt - start), 32'(len));
    if (!early) begin
      chk("busy_before_done", 32'(busy), 1);
      wr_burst_done = 1'b1;
      step();
      wr_burst_done = 1'b0;
    end
    chk("busy_after_done", 32'(busy), 0);
    model_addr = (model_addr + len > LIMIT) ? 0 : model_addr + len;
  endtask

  typedef struct {
    int n_push;
    bit flush;
    int exp_len;
    int exp_addr;
    int mode;
    bit early;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int level;
    int t;

    vecs[0] = '{8, 1'b0, 8, 0,  0, 1'b0};
    vecs[1] = '{8, 1'b0, 8, 8,  1, 1'b0};
    vecs[2] = '{8, 1'b0, 8, 16, 0, 1'b0};
    vecs[3] = '{8, 1'b0, 8, 24, 1, 1'b0};
    vecs[4] = '{7, 1'b0, 0, 0,  0, 1'b0};
    vecs[5] = '{0, 1'b1, 7, 0,  0, 1'b0};
    vecs[6] = '{8, 1'b0, 8, 7,  0, 1'b1};

    // Reset state
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    wr_data_req = 1'b1;
    #1;
    chk("rst_fifo_rd_req", 32'(fifo_rd_req), 0);
    wr_data_req = 1'b0;
    step();
    chk("rst_wr_burst_req", 32'(wr_burst_req), 0);
    chk("rst_wr_burst_addr", 32'(wr_burst_addr), 0);
    chk("rst_wr_burst_len", 32'(wr_burst_len), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_busy", 32'(busy), 0);

    // Table-driven bursts: full bursts through the ring wrap, held-back partial, flush, early done
    enable = 1'b1;
    for (int v = 0; v < 7; v++) begin
      flush = vecs[v].flush;
      push_words(vecs[v].n_push, 1'b0);
      if (vecs[v].exp_len == 0) no_req_for("no_req_partial", 10);
      else do_burst(vecs[v].exp_len, vecs[v].exp_addr, vecs[v].mode, vecs[v].early);
      flush = 1'b0;
    end

    // enable gating: 20 words buffered -> two full bursts, four left behind
    enable = 1'b0;
    push_words(20, 1'b1);
    no_req_for("no_req_disabled", 6);
    enable = 1'b1;
    do_burst(8, model_addr, 0, 1'b0);
    do_burst(8, model_addr, 2, 1'b0);
    no_req_for("no_req_remainder", 4);
    chk("fifo_level_remainder", 32'(fifo_use_num), 4);
    flush = 1'b1;
    do_burst(4, model_addr, 1, 1'b0);
    flush = 1'b0;

    // Reset mid-DATA after three pops
    push_words(8, 1'b0);
    t = 0;
    while (wr_burst_req !== 1'b1 && t < 60) begin
      step();
      t++;
    end
    chk("req_seen_rst_case", 32'(wr_burst_req), 1);
    wr_burst_ack = 1'b1;
    step();
    wr_burst_ack = 1'b0;
    wr_data_req = 1'b1;
    for (int i = 0; i < 3; i++) step();
    wr_data_req = 1'b0;
    rst = 1'b1;
    fifo_clr = 1'b1;
    step();
    pipe0 = 1'b0;
    pipe1 = 1'b0;
    exp_q.delete();
    rst = 1'b0;
    fifo_clr = 1'b0;
    wr_data_req = 1'b1;
    #1;
    chk("midrst_fifo_rd_req", 32'(fifo_rd_req), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_wr_burst_req", 32'(wr_burst_req), 0);
    chk("midrst_wr_burst_addr", 32'(wr_burst_addr), 0);
    chk("midrst_wr_data", 32'(wr_data), 0);
    wr_data_req = 1'b0;
    model_addr = 0;
    step();
    step();

    // Randomized rounds against the arithmetic model of level and address
    for (int r = 0; r < 6; r++) begin
      enable = 1'b0;
      level = $urandom_range(1, 20);
      push_words(level, 1'b1);
      step();
      enable = 1'b1;
      while (level >= BL) begin
        do_burst(BL, model_addr, $urandom_range(0, 2), 1'b0);
        level -= BL;
      end
      if (level > 0) begin
        no_req_for("no_req_random", 4);
        flush = 1'b1;
        do_burst(level, model_addr, $urandom_range(0, 2), 1'b0);
        flush = 1'b0;
      end
      chk("fifo_level_random", 32'(fifo_use_num), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
